// File: rtl/memory_responder.sv
// memory_responder: wait-state memory responder for the accumulator CPU bus.
// Captures one request, waits, accesses RAM, then pulses Ready/Err.
module memory_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int DEPTH       = 24,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req,
    input  logic                  memRW,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [3:0]          WAIT_M1 = 4'(WAIT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  commit;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_rw;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_in_rng;
    logic                  mem_we;

    // Next-state, capture and access decisions for the request FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    rw_d    = memRW;
                    wdata_d = WData;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                err_d   = ({1'b0, addr_q} >= DEPTH_W);
            end
            default: state_d = IDLE;
        endcase

        // zero-wait access uses the request as it is being captured
        acc_addr   = (state_q == IDLE) ? Addr  : addr_q;
        acc_rw     = (state_q == IDLE) ? memRW : rw_q;
        acc_wdata  = (state_q == IDLE) ? WData : wdata_q;
        acc_in_rng = ({1'b0, acc_addr} < DEPTH_W);

        if (commit) begin
            if (acc_rw) begin
                rdata_d = acc_in_rng ? mem[acc_addr] : '0;
            end else begin
                mem_we = acc_in_rng;
            end
        end

        // busy spans the wait/resp states and the Ready cycle itself
        busy_d = (state_d != IDLE) | ready_d;
    end

    // FSM and registered outputs; reset wins over any pending access
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // RAM write port; contents survive reset but a reset edge blocks the commit
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign RData = rdata_q;
    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: random and directed checks of memory_responder
// against a transaction-level memory model (2-wait and 0-wait instances).
module tb_memory_responder;

    logic       clk;
    logic       rst   [2];
    logic       req   [2];
    logic       rw    [2];
    logic [4:0] addr  [2];
    logic [7:0] wdat  [2];
    logic [7:0] rdat  [2];
    logic       rdy   [2];
    logic       bsy   [2];
    logic       er    [2];

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_m  [2][32];
    logic [7:0] exp_rd [2];

    memory_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .WAIT_CYCLES(2)
    ) u_w2 (
        .CLK(clk), .RST(rst[0]), .Req(req[0]), .memRW(rw[0]),
        .Addr(addr[0]), .WData(wdat[0]), .RData(rdat[0]),
        .Ready(rdy[0]), .Busy(bsy[0]), .Err(er[0])
    );

    memory_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .WAIT_CYCLES(0)
    ) u_w0 (
        .CLK(clk), .RST(rst[1]), .Req(req[1]), .memRW(rw[1]),
        .Addr(addr[1]), .WData(wdat[1]), .RData(rdat[1]),
        .Ready(rdy[1]), .Busy(bsy[1]), .Err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction, started at a negedge with the unit idle.
    // Ends at the negedge where the next request may be driven.
    task automatic run_txn(input int u, input bit rd, input int a,
                           input int d, input bit coll, input int ca,
                           input int cd, input bit kill);
        int  w;
        bit  oor;
        w   = (u == 0) ? 2 : 0;
        oor = (a >= 24);
        req[u]  = 1'b1;
        rw[u]   = rd;
        addr[u] = 5'(a);
        wdat[u] = 8'(d);
        if (kill) begin
            exp_rd[u] = 8'h00;
        end else if (rd) begin
            exp_rd[u] = oor ? 8'h00 : mem_m[u][a];
        end else if (!oor) begin
            mem_m[u][a] = 8'(d);
        end
        for (int i = 0; i <= w + 1; i++) begin
            @(negedge clk);
            chk($sformatf("u%0d busy a=%0d i=%0d", u, a, i), 32'(bsy[u]),
                32'(kill ? (i < w) : (i <= w + 1)));
            chk($sformatf("u%0d ready a=%0d i=%0d", u, a, i), 32'(rdy[u]),
                32'(!kill && i == w + 1));
            chk($sformatf("u%0d err a=%0d i=%0d", u, a, i), 32'(er[u]),
                32'(!kill && i == w + 1 && oor));
            if (i == w + 1 || kill) begin
                if (!kill || i >= w)
                    chk($sformatf("u%0d rdata a=%0d i=%0d", u, a, i),
                        32'(rdat[u]), 32'(exp_rd[u]));
            end
            if (coll && !kill && i <= w) begin
                req[u]  = 1'b1;
                rw[u]   = 1'b0;
                addr[u] = 5'(ca);
                wdat[u] = 8'(cd);
            end else begin
                req[u]  = 1'b0;
                addr[u] = 5'($urandom_range(0, 31));
                wdat[u] = 8'($urandom);
                rw[u]   = 1'($urandom);
            end
            rst[u] = (kill && i + 1 == w);
        end
    endtask

    task automatic idle_chk(input int u);
        @(negedge clk);
        chk($sformatf("u%0d idle busy", u), 32'(bsy[u]), 32'd0);
        chk($sformatf("u%0d idle ready", u), 32'(rdy[u]), 32'd0);
        chk($sformatf("u%0d idle rdata", u), 32'(rdat[u]), 32'(exp_rd[u]));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b1; rw[u] = 1'b0;
            addr[u] = 5'd3; wdat[u] = 8'hEE; exp_rd[u] = 8'h00;
            for (int a = 0; a < 32; a++) mem_m[u][a] = 8'h00;
        end
        @(negedge clk);

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("rst u%0d ready c%0d", u, c), 32'(rdy[u]), 0);
                chk($sformatf("rst u%0d busy c%0d", u, c), 32'(bsy[u]), 0);
                chk($sformatf("rst u%0d err c%0d", u, c), 32'(er[u]), 0);
                chk($sformatf("rst u%0d rdata c%0d", u, c), 32'(rdat[u]), 0);
            end
        end
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; req[u] = 1'b0;
        end
        idle_chk(0);
        idle_chk(1);

        for (int a = 0; a < 24; a++) run_txn(0, 0, a, 0, 0, 0, 0, 0);
        for (int a = 0; a < 24; a++) run_txn(1, 0, a, 0, 0, 0, 0, 0);

        run_txn(0, 0, 3, 8'hA5, 0, 0, 0, 0);
        run_txn(0, 1, 3, 0, 0, 0, 0, 0);
        chk("dir read3", 32'(rdat[0]), 32'hA5);
        run_txn(0, 0, 30, 8'hFF, 0, 0, 0, 0);
        run_txn(0, 1, 30, 0, 0, 0, 0, 0);
        run_txn(0, 1, 6, 0, 0, 0, 0, 0);
        run_txn(0, 1, 3, 0, 1, 4, 8'h11, 0);
        idle_chk(0);
        run_txn(0, 1, 4, 0, 0, 0, 0, 0);
        chk("dir addr4 untouched", 32'(rdat[0]), 32'h00);
        run_txn(0, 0, 7, 8'h5A, 0, 0, 0, 1);
        idle_chk(0);
        run_txn(0, 1, 7, 0, 0, 0, 0, 0);
        chk("dir addr7 prior", 32'(rdat[0]), 32'h00);

        run_txn(1, 0, 0, 8'h01, 0, 0, 0, 0);
        run_txn(1, 0, 1, 8'h02, 0, 0, 0, 0);
        run_txn(1, 1, 0, 0, 0, 0, 0, 0);
        chk("w0 read0", 32'(rdat[1]), 32'h01);
        run_txn(1, 1, 1, 0, 0, 0, 0, 0);
        chk("w0 read1", 32'(rdat[1]), 32'h02);
        idle_chk(1);

        for (int n = 0; n < 80; n++) begin
            run_txn(0, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 255),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
                    $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle_chk(0);
        end
        for (int n = 0; n < 60; n++) begin
            run_txn(1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 255),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 31),
                    $urandom_range(0, 255), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_chk(1);
        end

        for (int a = 0; a < 24; a++) run_txn(0, 1, a, 0, 0, 0, 0, 0);
        for (int a = 0; a < 24; a++) run_txn(1, 1, a, 0, 0, 0, 0, 0);
        idle_chk(0);
        idle_chk(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side responder for the accumulator CPU's memory bus. It accepts a single read or write request from the control unit's memory-request port (address, read/write select, write data), inserts a fixed number of wait states, and then performs the access on an internal word-addressed RAM. It returns a one-cycle completion pulse, plus read data or an out-of-range error. It sits between the control unit's AR/DR datapath and storage, so the control FSM can be extended with wait-for-ready states.

## Interface
- DATA_WIDTH, 8, width of memory words and of WData/RData
- ADDR_WIDTH, 5, width of Addr
- DEPTH, 24, number of implemented words; valid addresses are 0..DEPTH-1 and DEPTH must be ≤ 2^ADDR_WIDTH
- WAIT_CYCLES, 2, wait states inserted between request acceptance and completion, range 0..15

- CLK  input  1  clock; all state updates on posedge
- RST  input  1  reset, synchronous, active-high
- Req  input  1  request strobe; sampled only in IDLE
- memRW  input  1  1 = read, 0 = write
- Addr  input  ADDR_WIDTH  word address
- WData  input  DATA_WIDTH  write data
- RData  output  DATA_WIDTH  registered read data; holds its value until the next read completes
- Ready  output  1  one-cycle completion pulse
- Busy  output  1  high while a request is outstanding (WAIT or RESP)
- Err  output  1  pulses together with Ready when the captured address ≥ DEPTH

## Operation
- Reset is synchronous and active-high. Clock is CLK; reset is RST.
- States:
  - IDLE: Busy = 0.
  - WAIT: counter counts wait states.
  - RESP: Ready = 1 for exactly one cycle.
- IDLE, Req = 1 at a posedge:
  - Capture Addr, memRW and WData into internal registers. Later changes on the inputs do not affect the request.
  - If WAIT_CYCLES = 0, go to RESP and perform the access on that same edge.
  - Otherwise go to WAIT with counter = WAIT_CYCLES − 1.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, go to RESP and perform the access.
- Access, captured address < DEPTH:
  - Read: RData ← mem[addr].
  - Write: mem[addr] ← data. RData is unchanged.
  - Err = 0.
- Access, captured address ≥ DEPTH:
  - Write is dropped.
  - Read sets RData ← 0.
  - Err = 1 during RESP.
- RESP always returns to IDLE on the next edge. Req asserted in RESP is ignored.
- Req asserted in WAIT or RESP is ignored. It is neither queued nor does it alter the captured request.
- A read issued after a completed write to the same address returns the new value.
- Reset:
  - State → IDLE, counter → 0, Ready = 0, Busy = 0, Err = 0, RData = 0.
  - RAM contents are not cleared by RST. Simulation initial contents are all zero.
- RST has priority over Req and over a pending access. If RST is high on the commit edge, the write is not committed and no Ready pulse occurs.

## Timing
- Req is sampled at edge N. Busy is high from edge N through edge N+1+WAIT_CYCLES.
- Ready and Err are high for the single cycle following edge N+1+WAIT_CYCLES. RData is valid in that same cycle.
- Minimum request spacing is WAIT_CYCLES+2 cycles. With WAIT_CYCLES = 0, one request can be accepted every 2 cycles.
- The control unit drives its signals on negedge. Req, Addr, memRW and WData must therefore be stable at the following posedge, and Ready is observed at the control unit's next negedge.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold RST high for 2 cycles with Req = 1 → Ready = 0, Busy = 0, Err = 0, RData = 0, and no request is accepted.
- Write then read, WAIT_CYCLES = 2:
  - Write 0xA5 to Addr 3 with Req at edge 0 → Busy is high over edges 0–3 and Ready pulses after edge 3.
  - Read Addr 3 → RData = 0xA5 with Ready, Err = 0.
- Out of range, DEPTH = 24:
  - Write 0xFF to Addr 30 → Ready and Err pulse together.
  - Read Addr 30 → RData = 0x00, Err = 1.
  - Read Addr 6 (30 mod 24) → RData equals its previous value.
- Busy collision: second Req (write 0x11 to Addr 4) during WAIT of a read of Addr 3 → exactly one Ready pulse, the read data is correct, and Addr 4 is unchanged.
- Reset mid-write: write 0x5A to Addr 7, assert RST on the commit edge → no Ready pulse; a later read of Addr 7 returns its prior value of 0x00.
- Zero-wait instance (WAIT_CYCLES = 0): requests every 2 cycles (write Addr 0 = 0x01, write Addr 1 = 0x02, read Addr 0, read Addr 1) → Ready one cycle after each Req; reads return 0x01 and then 0x02.
